audio_pwm_out: RTL

Parametrised audio output stage between the adaptive FIR output and the `aud_pwm` pin. It succeeds the fixed 8-bit free-running PWM and the separate volume shifter. It accepts signed samples over a valid/ready handshake and applies an arithmetic-shift volume and a mute. It converts each sample to offset-binary duty and updates duty only on PWM period boundaries, so edges never glitch. It flags underruns when no sample has arrived by the end of a period.

---
 rtl/audio_pwm_out_if.sv | 22 ++
 rtl/audio_pwm_out.sv | 106 ++++++++++
 2 files changed

// File: rtl/audio_pwm_out_if.sv
// Sample stream handshake between the FIR output and the PWM output stage.
interface audio_pwm_out_if #(
    parameter int unsigned IN_WIDTH = 16
);
    logic [IN_WIDTH-1:0] sample;
    logic                valid;
    logic                ready;

    // Producer side: drives samples, observes back-pressure.
    modport master (
        output sample,
        output valid,
        input  ready
    );

    // Consumer side: the PWM output stage.
    modport slave (
        input  sample,
        input  valid,
        output ready
    );
endinterface

// File: rtl/audio_pwm_out.sv
// Audio PWM output stage: one-entry sample buffer, shift volume, mute, and
// duty updates only on period boundaries. Define AUDIO_PWM_DITHER_EN to add
// LFSR dither ahead of truncation to PWM resolution.
module audio_pwm_out #(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned PWM_WIDTH = 8,
    parameter int unsigned VOL_WIDTH = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    audio_pwm_out_if.slave       bus,
    input  logic [VOL_WIDTH-1:0] vol_in,
    input  logic                 mute_in,
    output logic                 pwm_out,
    output logic                 period_start_out,
    output logic                 underrun_out
);
    localparam int unsigned DROP = IN_WIDTH - PWM_WIDTH;
    localparam logic [PWM_WIDTH-1:0] CNT_MAX = {PWM_WIDTH{1'b1}};
    localparam logic [PWM_WIDTH-1:0] MID     = {1'b1, {(PWM_WIDTH-1){1'b0}}};

    logic [PWM_WIDTH-1:0]        count;
    logic [PWM_WIDTH-1:0]        level;
    logic [PWM_WIDTH-1:0]        level_next_c;
    logic [IN_WIDTH-1:0]         pend;
    logic                        pend_valid;
    logic [VOL_WIDTH-1:0]        shift_c;
    logic signed [IN_WIDTH-1:0]  scaled_c;
    logic [IN_WIDTH-1:0]         trunc_c;
    logic                        period_end_c;
    logic                        accept_c;

    assign period_end_c = (count == CNT_MAX);
    assign bus.ready    = !rst_in && !pend_valid;
    assign accept_c     = bus.valid && bus.ready;

`ifdef AUDIO_PWM_DITHER_EN
    logic [15:0]       lfsr;
    logic [IN_WIDTH:0] sum_c;

    // Dither sequence, stepped once per period end.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            lfsr <= 16'hACE1;
        end else if (period_end_c) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Add dither below the kept bits; saturate on positive overflow.
    always_comb begin
        sum_c = {scaled_c[IN_WIDTH-1], scaled_c} + (IN_WIDTH+1)'(lfsr[DROP-1:0]);
        if (!sum_c[IN_WIDTH] && sum_c[IN_WIDTH-1]) begin
            trunc_c = {1'b0, {(IN_WIDTH-1){1'b1}}};
        end else begin
            trunc_c = sum_c[IN_WIDTH-1:0];
        end
    end
`else
    // Plain truncation.
    always_comb begin
        trunc_c = scaled_c;
    end
`endif

    // Volume shift, then top bits with inverted MSB give offset-binary duty.
    always_comb begin
        shift_c  = ~vol_in;
        scaled_c = $signed(pend) >>> shift_c;
        if (mute_in) begin
            level_next_c = MID;
        end else begin
            level_next_c = PWM_WIDTH'(trunc_c >> DROP) ^ MID;
        end
    end

    // Period counter, PWM compare and boundary pulses.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count            <= '0;
            pwm_out          <= 1'b0;
            period_start_out <= 1'b0;
            underrun_out     <= 1'b0;
        end else begin
            count            <= count + PWM_WIDTH'(1);
            pwm_out          <= (count < level);
            period_start_out <= period_end_c;
            underrun_out     <= period_end_c && !pend_valid;
        end
    end

    // Pending slot: filled on accept, drained into level at period end.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            level      <= MID;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else if (period_end_c && pend_valid) begin
            level      <= level_next_c;
            pend_valid <= 1'b0;
        end else if (accept_c) begin
            pend       <= bus.sample;
            pend_valid <= 1'b1;
        end
    end
endmodule
